// File: rtl/bidir_port_pkg.sv
// Shared encodings for the bidirectional pad sequencer.
// One-hot FSM states and last-operation flags.
package bidir_port_pkg;

  localparam int I_IDLE     = 0;
  localparam int I_PRETURN  = 1;
  localparam int I_DRIVE    = 2;
  localparam int I_POSTTURN = 3;
  localparam int I_SAMPLE   = 4;
  localparam int I_DONE     = 5;

  localparam logic [5:0] ST_IDLE     = 6'b000001;
  localparam logic [5:0] ST_PRETURN  = 6'b000010;
  localparam logic [5:0] ST_DRIVE    = 6'b000100;
  localparam logic [5:0] ST_POSTTURN = 6'b001000;
  localparam logic [5:0] ST_SAMPLE   = 6'b010000;
  localparam logic [5:0] ST_DONE     = 6'b100000;

  typedef enum logic [5:0] {
    S_IDLE     = ST_IDLE,
    S_PRETURN  = ST_PRETURN,
    S_DRIVE    = ST_DRIVE,
    S_POSTTURN = ST_POSTTURN,
    S_SAMPLE   = ST_SAMPLE,
    S_DONE     = ST_DONE
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bidir_port_ctrl_sync_bus.sv
// Multi-flop synchronizer for the pad readback bus.
// All stages clear to zero on reset.
module sync_bus #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [SYNC_STAGES];

  // Shift the asynchronous pad value through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_port_ctrl.sv
// Pad sequencer: request handshake to IOBUF I/T control
// with guaranteed high-Z turnaround and synchronized readback.
module bidir_port_ctrl
  import bidir_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_REQ,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             RD_REQ,
  output logic             ACK,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             BUSY,
  output logic [WIDTH-1:0] PAD_I,
  output logic             PAD_T,
  input  logic [WIDTH-1:0] PAD_O
);

  localparam int MX = max3(HOLD_CYCLES, TURN_CYCLES, SYNC_STAGES + 1);
  localparam int CW = $clog2(MX + 1);
  localparam int TV = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
  localparam logic [CW-1:0] HL = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TL = CW'(TV);
  localparam logic [CW-1:0] SL = CW'(SYNC_STAGES);
  localparam bit HAS_TURN = (TURN_CYCLES > 0);

  state_e          state;
  state_e          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            last_op;
  logic [WIDTH-1:0] sync_q;
  logic            wr_acc;
  logic            rd_done;

  sync_bus #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(CLK),
    .rst(RST),
    .d  (PAD_O),
    .q  (sync_q)
  );

  assign wr_acc  = state[I_IDLE] && !ACK && WR_REQ;
  assign rd_done = state[I_SAMPLE] && (cnt == '0);
  assign BUSY    = !state[I_IDLE];

  // Next state and counter reload on every state entry
  always_comb begin
    state_next = state;
    cnt_next   = (cnt != '0) ? cnt - 1'b1 : '0;
    unique case (1'b1)
      state[I_IDLE]: begin
        if (!ACK) begin
          if (WR_REQ) begin
            if (last_op == OP_READ && HAS_TURN) begin
              state_next = S_PRETURN;
              cnt_next   = TL;
            end else begin
              state_next = S_DRIVE;
              cnt_next   = HL;
            end
          end else if (RD_REQ) begin
            state_next = S_SAMPLE;
            cnt_next   = SL;
          end
        end
      end
      state[I_PRETURN]: begin
        if (cnt == '0) begin
          state_next = S_DRIVE;
          cnt_next   = HL;
        end
      end
      state[I_DRIVE]: begin
        if (cnt == '0) begin
          if (HAS_TURN) begin
            state_next = S_POSTTURN;
            cnt_next   = TL;
          end else begin
            state_next = S_DONE;
            cnt_next   = '0;
          end
        end
      end
      state[I_POSTTURN]: begin
        if (cnt == '0) begin
          state_next = S_DONE;
          cnt_next   = '0;
        end
      end
      state[I_SAMPLE]: begin
        if (cnt == '0) begin
          state_next = S_DONE;
          cnt_next   = '0;
        end
      end
      state[I_DONE]: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and registered pad/handshake outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last_op  <= OP_READ;
      PAD_T    <= 1'b1;
      PAD_I    <= '0;
      ACK      <= 1'b0;
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      PAD_T    <= (state_next != S_DRIVE);
      ACK      <= (state_next == S_DONE);
      RD_VALID <= rd_done;
      if (wr_acc) PAD_I <= WR_DATA;
      if (rd_done) begin
        RD_DATA <= sync_q;
        last_op <= OP_READ;
      end
      if (state_next == S_DRIVE) last_op <= OP_WRITE;
    end
  end

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Directed bench for bidir_port_ctrl.
// Hand-computed cycle expectations, checked by immediate assertions.
module tb_bidir_port_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR_REQ = 1'b0;
  logic [7:0] WR_DATA = '0;
  logic       RD_REQ = 1'b0;
  logic       ACK;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
  logic       BUSY;
  logic [7:0] PAD_I;
  logic       PAD_T;
  logic [7:0] PAD_O = '0;

  int n_chk = 0;
  int n_fail = 0;

  bidir_port_ctrl dut (
    .CLK     (CLK),
    .RST     (RST),
    .WR_REQ  (WR_REQ),
    .WR_DATA (WR_DATA),
    .RD_REQ  (RD_REQ),
    .ACK     (ACK),
    .RD_DATA (RD_DATA),
    .RD_VALID(RD_VALID),
    .BUSY    (BUSY),
    .PAD_I   (PAD_I),
    .PAD_T   (PAD_T),
    .PAD_O   (PAD_O)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {PAD_T, BUSY, ACK, RD_VALID}
  function automatic logic [3:0] ctl();
    return {PAD_T, BUSY, ACK, RD_VALID};
  endfunction

  initial begin
    // 1: reset held, then idle
    tick(); tick(); tick();
    chk("rst_ctl", {28'h0, ctl()}, 32'h8);
    chk("rst_padi", {24'h0, PAD_I}, 32'h00);
    chk("rst_rdd", {24'h0, RD_DATA}, 32'h00);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ctl", {28'h0, ctl()}, 32'h8);
      chk("idle_padi", {24'h0, PAD_I}, 32'h00);
    end

    // 2: first write A5, PRETURN because last op was read
    PAD_O = 8'h3C;
    WR_DATA = 8'hA5;
    WR_REQ = 1'b1;
    tick();
    chk("w1_preturn", {28'h0, ctl()}, 32'hC);
    tick();
    chk("w1_drive0", {28'h0, ctl()}, 32'h4);
    chk("w1_padi", {24'h0, PAD_I}, 32'hA5);
    tick();
    chk("w1_drive1", {28'h0, ctl()}, 32'h4);
    chk("w1_padi1", {24'h0, PAD_I}, 32'hA5);
    tick();
    chk("w1_post", {28'h0, ctl()}, 32'hC);
    chk("w1_post_padi", {24'h0, PAD_I}, 32'hA5);
    tick();
    chk("w1_ack", {28'h0, ctl()}, 32'hE);
    WR_REQ = 1'b0;
    tick();
    chk("w1_idle", {28'h0, ctl()}, 32'h8);

    // 3: read of 3C, DONE four cycles after acceptance
    RD_REQ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r1_sample", {28'h0, ctl()}, 32'hC);
    end
    tick();
    chk("r1_done", {28'h0, ctl()}, 32'hF);
    chk("r1_data", {24'h0, RD_DATA}, 32'h3C);
    RD_REQ = 1'b0;
    tick();
    chk("r1_idle", {28'h0, ctl()}, 32'h8);
    chk("r1_hold", {24'h0, RD_DATA}, 32'h3C);

    // 4: simultaneous write 0F and read F0; write first
    WR_DATA = 8'h0F;
    PAD_O = 8'hF0;
    WR_REQ = 1'b1;
    RD_REQ = 1'b1;
    tick();
    chk("c_preturn", {28'h0, ctl()}, 32'hC);
    tick();
    chk("c_drive", {28'h0, ctl()}, 32'h4);
    chk("c_padi", {24'h0, PAD_I}, 32'h0F);
    tick();
    tick();
    chk("c_post", {28'h0, ctl()}, 32'hC);
    tick();
    chk("c_wack", {28'h0, ctl()}, 32'hE);
    WR_REQ = 1'b0;
    tick();
    chk("c_idle", {28'h0, ctl()}, 32'h8);
    tick();
    chk("c_sample", {28'h0, ctl()}, 32'hC);
    tick();
    tick();
    tick();
    chk("c_rdone", {28'h0, ctl()}, 32'hF);
    chk("c_rdata", {24'h0, RD_DATA}, 32'hF0);
    RD_REQ = 1'b0;
    tick();
    chk("c_idle2", {28'h0, ctl()}, 32'h8);

    // 6: back-to-back writes 11 then 22
    WR_DATA = 8'h11;
    WR_REQ = 1'b1;
    tick();
    chk("b_preturn", {28'h0, ctl()}, 32'hC);
    tick();
    chk("b_drive_a", {28'h0, ctl()}, 32'h4);
    chk("b_padi_a", {24'h0, PAD_I}, 32'h11);
    tick();
    chk("b_drive_a1", {28'h0, ctl()}, 32'h4);
    tick();
    chk("b_gap0", {28'h0, ctl()}, 32'hC);
    tick();
    chk("b_gap1_ack", {28'h0, ctl()}, 32'hE);
    WR_DATA = 8'h22;
    tick();
    chk("b_gap2_idle", {28'h0, ctl()}, 32'h8);
    tick();
    chk("b_drive_b", {28'h0, ctl()}, 32'h4);
    chk("b_padi_b", {24'h0, PAD_I}, 32'h22);
    tick();
    chk("b_drive_b1", {28'h0, ctl()}, 32'h4);
    tick();
    chk("b_post", {28'h0, ctl()}, 32'hC);
    tick();
    chk("b_ack", {28'h0, ctl()}, 32'hE);
    WR_REQ = 1'b0;
    tick();
    chk("b_idle", {28'h0, ctl()}, 32'h8);

    // 5: async reset mid-DRIVE
    WR_DATA = 8'h5A;
    WR_REQ = 1'b1;
    tick();
    chk("a_drive", {28'h0, ctl()}, 32'h4);
    chk("a_padi", {24'h0, PAD_I}, 32'h5A);
    #3;
    RST = 1'b1;
    #1;
    chk("a_rst_ctl", {28'h0, ctl()}, 32'h8);
    chk("a_rst_padi", {24'h0, PAD_I}, 32'h00);
    chk("a_rst_rdd", {24'h0, RD_DATA}, 32'h00);
    WR_REQ = 1'b0;
    tick();
    chk("a_rst_hold", {28'h0, ctl()}, 32'h8);
    tick();
    RST = 1'b0;
    tick();
    chk("a_after", {28'h0, ctl()}, 32'h8);

    // last op is READ again after reset: PRETURN returns
    WR_DATA = 8'h77;
    WR_REQ = 1'b1;
    tick();
    chk("p_preturn", {28'h0, ctl()}, 32'hC);
    tick();
    chk("p_drive", {28'h0, ctl()}, 32'h4);
    chk("p_padi", {24'h0, PAD_I}, 32'h77);
    tick();
    tick();
    tick();
    chk("p_ack", {28'h0, ctl()}, 32'hE);
    WR_REQ = 1'b0;
    tick();
    chk("p_idle", {28'h0, ctl()}, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
